mips_debug_ctrl: RTL

//  Debug controller that sequences the 5-stage MIPS core from a host byte stream (UART RX/TX bytes).

---
 rtl/mips_dbg_pkg.sv | 39 +++
 rtl/dbg_word_tx.sv | 48 ++++
 rtl/mips_debug_ctrl.sv | 277 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/mips_dbg_pkg.sv
// Shared definitions for the MIPS debug controller: host command codes,
// the HALT instruction word, FSM state encoding and dump length.
// Optional feature macro: MIPS_DBG_CYCLE_COUNT_EN appends a 32-bit count of
// enabled core cycles to every register dump.
package mips_dbg_pkg;

  localparam logic [7:0]  CMD_LOAD  = 8'h4C;  // 'L'
  localparam logic [7:0]  CMD_RESET = 8'h52;  // 'R'
  localparam logic [7:0]  CMD_RUN   = 8'h43;  // 'C'
  localparam logic [7:0]  CMD_STEP  = 8'h53;  // 'S'
  localparam logic [7:0]  CMD_ACK   = 8'h4B;  // 'K'

  localparam logic [31:0] HALT_WORD = 32'hFFFF_FFFF;

  localparam int NUM_GPR = 32;

  // Words in one dump, PC included
`ifdef MIPS_DBG_CYCLE_COUNT_EN
  localparam int DUMP_WORDS = 34;
`else
  localparam int DUMP_WORDS = 33;
`endif
  localparam int DUMP_BYTES = 4 * DUMP_WORDS;

  typedef enum logic [3:0] {
    ST_IDLE       = 4'd0,
    ST_LOAD_BYTE  = 4'd1,
    ST_LOAD_WR    = 4'd2,
    ST_PRST       = 4'd3,
    ST_RUN        = 4'd4,
    ST_STEP       = 4'd5,
    ST_DUMP_PC    = 4'd6,
    ST_DUMP_RADDR = 4'd7,
    ST_DUMP_RWAIT = 4'd8,
    ST_DUMP_SEND  = 4'd9,
    ST_ACK        = 4'd10
  } dbg_state_e;

endpackage

// File: rtl/dbg_word_tx.sv
// Word-to-byte serializer: takes a 32-bit word (or a single byte placed in
// the top byte) and presents it MSB first on a valid/ready byte channel.
// The byte on tx_data comes straight from a register, so it stays stable
// while tx_valid is high and the sink is not ready.
module dbg_word_tx (
  input  logic        clk,
  input  logic        rst,
  input  logic        load,
  input  logic [31:0] word,
  input  logic        single_byte,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  output logic        busy,
  output logic        done
);

  logic [31:0] shreg_r;
  logic [1:0]  left_r;
  logic        busy_r;
  logic        fire_s;
  logic        last_s;

  assign fire_s   = busy_r & tx_ready;
  assign last_s   = (left_r == 2'd0);
  assign tx_data  = shreg_r[31:24];
  assign tx_valid = busy_r;
  assign busy     = busy_r;
  assign done     = fire_s & last_s;

  // Load a word, then shift out one byte per accepted handshake
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shreg_r <= 32'h0;
      left_r  <= 2'd0;
      busy_r  <= 1'b0;
    end else if (load) begin
      shreg_r <= word;
      left_r  <= single_byte ? 2'd0 : 2'd3;
      busy_r  <= 1'b1;
    end else if (fire_s) begin
      shreg_r <= {shreg_r[23:0], 8'h00};
      left_r  <= left_r - 2'd1;
      busy_r  <= ~last_s;
    end
  end

endmodule

// File: rtl/mips_debug_ctrl.sv
// Debug controller for the 5-stage MIPS core. Decodes host commands from
// the UART byte stream, loads instruction memory, pulses the core reset,
// runs or single-steps the pipeline and dumps PC + GPRs back to the host.
// Optional feature macro: MIPS_DBG_CYCLE_COUNT_EN (enabled-cycle counter
// appended to each dump).
module mips_debug_ctrl #(
  parameter int NB_ADDR    = 32,
  parameter int NB_DATA    = 32,
  parameter int NB_REG     = 5,
  parameter int IMEM_DEPTH = 256
) (
  input  logic               i_clk,
  input  logic               i_reset,
  input  logic [7:0]         i_rx_data,
  input  logic               i_rx_valid,
  output logic [7:0]         o_tx_data,
  output logic               o_tx_valid,
  input  logic               i_tx_ready,
  output logic               o_pipe_enable,
  output logic               o_pipe_reset,
  output logic               o_imem_write,
  output logic [NB_ADDR-1:0] o_imem_addr,
  output logic [NB_DATA-1:0] o_imem_data,
  output logic [NB_REG-1:0]  o_dbg_reg_addr,
  input  logic [NB_DATA-1:0] i_dbg_reg_data,
  input  logic [NB_ADDR-1:0] i_pc,
  input  logic               i_halt
);

  import mips_dbg_pkg::*;

  localparam int               PTR_W    = $clog2(IMEM_DEPTH + 1);
  localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(IMEM_DEPTH - 1);
  // word_idx_r counts words sent after the PC; LAST_IDX means all are queued
  localparam logic [5:0]       LAST_IDX = 6'(DUMP_WORDS - 1);
  localparam logic [5:0]       GPR_END  = 6'(NUM_GPR);

  dbg_state_e         state_r;
  dbg_state_e         state_nxt_s;

  logic [1:0]         byte_cnt_r;
  logic [23:0]        asm_r;
  logic [PTR_W-1:0]   ptr_r;
  logic [5:0]         word_idx_r;
  logic               imem_write_r;
  logic [NB_ADDR-1:0] imem_addr_r;
  logic [NB_DATA-1:0] imem_data_r;
  logic               pipe_reset_r;
  logic [NB_REG-1:0]  dbg_addr_r;

  logic               cmd_load_s;
  logic               cmd_reset_s;
  logic               accept_byte_s;
  logic               wr_issue_s;
  logic               tx_load_s;
  logic [31:0]        tx_word_s;
  logic               tx_single_s;
  logic               tx_busy_s;
  logic               tx_done_s;
  logic [31:0]        extra_word_s;

  assign o_pipe_enable  = ((state_r == ST_RUN) & ~i_halt) | (state_r == ST_STEP);
  assign o_pipe_reset   = pipe_reset_r;
  assign o_imem_write   = imem_write_r;
  assign o_imem_addr    = imem_addr_r;
  assign o_imem_data    = imem_data_r;
  assign o_dbg_reg_addr = dbg_addr_r;

`ifdef MIPS_DBG_CYCLE_COUNT_EN
  logic [31:0] cyc_cnt_r;

  // Count cycles the core was enabled since the last reset or 'R' command
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      cyc_cnt_r <= 32'h0;
    end else if (cmd_reset_s) begin
      cyc_cnt_r <= 32'h0;
    end else if (o_pipe_enable) begin
      cyc_cnt_r <= cyc_cnt_r + 32'd1;
    end
  end

  assign extra_word_s = cyc_cnt_r;
`else
  assign extra_word_s = 32'h0;
`endif

  // State register
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next-state decode and per-cycle control strobes
  always_comb begin
    state_nxt_s   = state_r;
    cmd_load_s    = 1'b0;
    cmd_reset_s   = 1'b0;
    accept_byte_s = 1'b0;
    wr_issue_s    = 1'b0;
    tx_load_s     = 1'b0;
    tx_word_s     = 32'h0;
    tx_single_s   = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (i_rx_valid) begin
          case (i_rx_data)
            CMD_LOAD: begin
              cmd_load_s  = 1'b1;
              state_nxt_s = ST_LOAD_BYTE;
            end
            CMD_RESET: begin
              cmd_reset_s = 1'b1;
              state_nxt_s = ST_PRST;
            end
            CMD_RUN:  state_nxt_s = ST_RUN;
            CMD_STEP: state_nxt_s = ST_STEP;
            default:  state_nxt_s = ST_IDLE;
          endcase
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_LOAD_BYTE: begin
        if (i_rx_valid) begin
          accept_byte_s = 1'b1;
          if (byte_cnt_r == 2'd3) begin
            wr_issue_s  = 1'b1;
            state_nxt_s = ST_LOAD_WR;
          end else begin
            state_nxt_s = ST_LOAD_BYTE;
          end
        end else begin
          state_nxt_s = ST_LOAD_BYTE;
        end
      end
      ST_LOAD_WR: begin
        // The word just written is either HALT or the last imem slot
        if ((imem_data_r == NB_DATA'(HALT_WORD)) || (ptr_r == PTR_LAST)) begin
          tx_load_s   = 1'b1;
          tx_word_s   = {CMD_ACK, 24'h0};
          tx_single_s = 1'b1;
          state_nxt_s = ST_ACK;
        end else begin
          state_nxt_s = ST_LOAD_BYTE;
        end
      end
      ST_PRST: begin
        tx_load_s   = 1'b1;
        tx_word_s   = {CMD_ACK, 24'h0};
        tx_single_s = 1'b1;
        state_nxt_s = ST_ACK;
      end
      ST_RUN: begin
        if (i_halt) begin
          state_nxt_s = ST_DUMP_PC;
        end else begin
          state_nxt_s = ST_RUN;
        end
      end
      ST_STEP: begin
        state_nxt_s = ST_DUMP_PC;
      end
      ST_DUMP_PC: begin
        // Serializer is idle here: every path into a dump starts from IDLE
        tx_load_s   = 1'b1;
        tx_word_s   = 32'(i_pc);
        state_nxt_s = ST_DUMP_RADDR;
      end
      ST_DUMP_RADDR: begin
        state_nxt_s = ST_DUMP_RWAIT;
      end
      ST_DUMP_RWAIT: begin
        state_nxt_s = ST_DUMP_SEND;
      end
      ST_DUMP_SEND: begin
        if (word_idx_r == LAST_IDX) begin
          // Everything queued; leave once the final byte has gone
          if (!tx_busy_s) begin
            state_nxt_s = ST_IDLE;
          end else begin
            state_nxt_s = ST_DUMP_SEND;
          end
        end else if (!tx_busy_s) begin
          tx_load_s = 1'b1;
          if (word_idx_r < GPR_END) begin
            tx_word_s = 32'(i_dbg_reg_data);
          end else begin
            tx_word_s = extra_word_s;
          end
          if (word_idx_r < (GPR_END - 6'd1)) begin
            state_nxt_s = ST_DUMP_RADDR;
          end else begin
            state_nxt_s = ST_DUMP_SEND;
          end
        end else begin
          state_nxt_s = ST_DUMP_SEND;
        end
      end
      ST_ACK: begin
        if (tx_done_s) begin
          state_nxt_s = ST_IDLE;
        end else begin
          state_nxt_s = ST_ACK;
        end
      end
      default: begin
        state_nxt_s = ST_IDLE;
      end
    endcase
  end

  // Load path: byte assembly, imem write port and load pointer
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      byte_cnt_r   <= 2'd0;
      asm_r        <= 24'h0;
      ptr_r        <= {PTR_W{1'b0}};
      imem_write_r <= 1'b0;
      imem_addr_r  <= {NB_ADDR{1'b0}};
      imem_data_r  <= {NB_DATA{1'b0}};
    end else begin
      imem_write_r <= wr_issue_s;
      if (cmd_load_s) begin
        byte_cnt_r <= 2'd0;
        ptr_r      <= {PTR_W{1'b0}};
      end else if (accept_byte_s) begin
        byte_cnt_r <= byte_cnt_r + 2'd1;
        asm_r      <= {asm_r[15:0], i_rx_data};
      end else if (state_r == ST_LOAD_WR) begin
        ptr_r <= ptr_r + PTR_W'(1);
      end
      if (wr_issue_s) begin
        imem_addr_r <= NB_ADDR'({ptr_r, 2'b00});
        imem_data_r <= NB_DATA'({asm_r, i_rx_data});
      end
    end
  end

  // Dump sequencing, register-file read address and core reset pulse
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      word_idx_r   <= 6'd0;
      dbg_addr_r   <= {NB_REG{1'b0}};
      pipe_reset_r <= 1'b0;
    end else begin
      pipe_reset_r <= cmd_reset_s;
      if (state_r == ST_DUMP_PC) begin
        word_idx_r <= 6'd0;
      end else if ((state_r == ST_DUMP_SEND) && tx_load_s) begin
        word_idx_r <= word_idx_r + 6'd1;
      end
      if (state_r == ST_DUMP_RADDR) begin
        dbg_addr_r <= NB_REG'(word_idx_r);
      end else if (state_r == ST_IDLE) begin
        dbg_addr_r <= {NB_REG{1'b0}};
      end
    end
  end

  dbg_word_tx u_word_tx (
    .clk         (i_clk),
    .rst         (i_reset),
    .load        (tx_load_s),
    .word        (tx_word_s),
    .single_byte (tx_single_s),
    .tx_data     (o_tx_data),
    .tx_valid    (o_tx_valid),
    .tx_ready    (i_tx_ready),
    .busy        (tx_busy_s),
    .done        (tx_done_s)
  );

endmodule
